// File: rtl/spmv_pkg.sv
// Shared types and constants for the SpMV row scheduler.
// Holds the FSM encoding, error bit positions and beat geometry.
package spmv_pkg;

  localparam int BEAT_ROWS  = 4;
  localparam int BEAT_SHIFT = $clog2(BEAT_ROWS);

  localparam int ERR_BAD_COUNT    = 0;
  localparam int ERR_ROWPTR_DEC   = 1;
  localparam int ERR_NNZ_MISMATCH = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BASE,
    S_ISSUE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/spmv_nnz_diff.sv
// Row-pointer to per-row NNZ difference stage.
// A single output register with pass-through ready gives full throughput.
module spmv_nnz_diff #(
  parameter int ROWS_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              base_en,
  input  logic              disp_en,
  input  logic [ROWS_W-1:0] rowptr_tdata,
  input  logic              rowptr_tvalid,
  output logic              rowptr_tready,
  output logic [31:0]       times_tdata,
  output logic              times_tvalid,
  input  logic              times_tready,
  output logic              row_fire,
  output logic [31:0]       row_diff,
  output logic              row_dec
);

  logic [ROWS_W-1:0] prev_q, prev_d;
  logic [31:0]       tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              rdy, fire, dfire, dec;
  logic [31:0]       diff;

  always_comb begin
    rdy      = base_en | (disp_en & (~tvalid_q | times_tready));
    fire     = rowptr_tvalid & rdy;
    dfire    = fire & disp_en;
    dec      = rowptr_tdata < prev_q;
    diff     = dec ? 32'd0 : 32'(rowptr_tdata - prev_q);
    prev_d   = prev_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    if (fire & base_en) prev_d = rowptr_tdata;
    if (times_tready) tvalid_d = 1'b0;
    if (dfire) begin
      tvalid_d = 1'b1;
      tdata_d  = diff;
      // A decreasing pointer is reported but never becomes the new base
      if (!dec) prev_d = rowptr_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      prev_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign rowptr_tready = rdy;
  assign times_tdata   = tdata_q;
  assign times_tvalid  = tvalid_q;
  assign row_fire      = dfire;
  assign row_diff      = diff;
  assign row_dec       = dec;

endmodule

// File: rtl/spmv_row_scheduler.sv
// Per-job sequencer: rowptr to TIMES, read start, result beat counting.
// Define SPMV_ROW_SCHED_PERF_EN to build the perf_cycles/perf_stall counters.
module spmv_row_scheduler
  import spmv_pkg::*;
#(
  parameter int ROWS_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_start,
  input  logic [ROWS_W-1:0] cfg_row_count,
  input  logic [31:0]       cfg_nnz_total,
  output logic              busy,
  output logic              done,
  output logic [2:0]        err,
  input  logic [ROWS_W-1:0] rowptr_tdata,
  input  logic              rowptr_tvalid,
  output logic              rowptr_tready,
  output logic              read_begin,
  output logic [31:0]       read_length,
  output logic [31:0]       times_tdata,
  output logic              times_tvalid,
  input  logic              times_tready,
  input  logic              out_beat_valid,
`ifdef SPMV_ROW_SCHED_PERF_EN
  input  logic              out_beat_ready,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stall
`else
  input  logic              out_beat_ready
`endif
);

  state_t            state_q, state_d;
  logic [ROWS_W-1:0] rc_q, rc_d;
  logic [31:0]       nnz_q, nnz_d;
  logic [2:0]        err_q, err_d;
  logic [ROWS_W-1:0] rows_q, rows_d;
  logic [31:0]       sum_q, sum_d;
  logic [ROWS_W-1:0] beats_q, beats_d;
  logic [31:0]       rlen_q, rlen_d;
  logic [ROWS_W-1:0] target;
  logic              base_en, disp_en, cnt_en;
  logic              row_fire, row_dec;
  logic [31:0]       row_diff;

  spmv_nnz_diff #(.ROWS_W(ROWS_W)) u_diff (
    .clk           (clk),
    .rstn          (rstn),
    .base_en       (base_en),
    .disp_en       (disp_en),
    .rowptr_tdata  (rowptr_tdata),
    .rowptr_tvalid (rowptr_tvalid),
    .rowptr_tready (rowptr_tready),
    .times_tdata   (times_tdata),
    .times_tvalid  (times_tvalid),
    .times_tready  (times_tready),
    .row_fire      (row_fire),
    .row_diff      (row_diff),
    .row_dec       (row_dec)
  );

  always_comb begin
    base_en = (state_q == S_BASE);
    disp_en = (state_q == S_DISPATCH) && (rows_q != rc_q);
    cnt_en  = (state_q == S_ISSUE) || (state_q == S_DISPATCH) ||
              (state_q == S_DRAIN);
    target  = rc_q >> BEAT_SHIFT;
    state_d = state_q;
    rc_d    = rc_q;
    nnz_d   = nnz_q;
    err_d   = err_q;
    rows_d  = rows_q;
    sum_d   = sum_q;
    rlen_d  = rlen_q;
    beats_d = beats_q;
    if (cnt_en && out_beat_valid && out_beat_ready)
      beats_d = beats_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          rc_d    = cfg_row_count;
          nnz_d   = cfg_nnz_total;
          err_d   = '0;
          rows_d  = '0;
          sum_d   = '0;
          beats_d = '0;
          if (cfg_row_count == '0 ||
              cfg_row_count[BEAT_SHIFT-1:0] != '0)
            err_d[ERR_BAD_COUNT] = 1'b1;
          else
            state_d = S_BASE;
        end
      end
      S_BASE: begin
        if (rowptr_tvalid && rowptr_tready) begin
          rlen_d  = nnz_q;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_DISPATCH;
      S_DISPATCH: begin
        if (row_fire) begin
          rows_d = rows_q + 1'b1;
          sum_d  = sum_q + row_diff;
          if (row_dec) err_d[ERR_ROWPTR_DEC] = 1'b1;
        end
        if (rows_q == rc_q && (!times_tvalid || times_tready)) begin
          state_d = S_DRAIN;
          if (sum_q != nnz_q) err_d[ERR_NNZ_MISMATCH] = 1'b1;
        end
      end
      // Early beats may already have satisfied the target
      S_DRAIN: if (beats_d >= target) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      rc_q    <= '0;
      nnz_q   <= '0;
      err_q   <= '0;
      rows_q  <= '0;
      sum_q   <= '0;
      beats_q <= '0;
      rlen_q  <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      nnz_q   <= nnz_d;
      err_q   <= err_d;
      rows_q  <= rows_d;
      sum_q   <= sum_d;
      beats_q <= beats_d;
      rlen_q  <= rlen_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign read_begin  = (state_q == S_ISSUE);
  assign read_length = rlen_q;
  assign err         = err_q;

`ifdef SPMV_ROW_SCHED_PERF_EN
  logic [31:0] pcyc_q, pcyc_d, pstl_q, pstl_d;

  always_comb begin
    pcyc_d = pcyc_q;
    pstl_d = pstl_q;
    if (state_q == S_IDLE && cfg_start) begin
      pcyc_d = '0;
      pstl_d = '0;
    end else begin
      if (busy && pcyc_q != '1) pcyc_d = pcyc_q + 1'b1;
      if (state_q == S_DISPATCH && times_tvalid && !times_tready &&
          pstl_q != '1)
        pstl_d = pstl_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pcyc_q <= '0;
      pstl_q <= '0;
    end else begin
      pcyc_q <= pcyc_d;
      pstl_q <= pstl_d;
    end
  end

  assign perf_cycles = pcyc_q;
  assign perf_stall  = pstl_q;
`endif

endmodule

// File: tb/tb_spmv_row_scheduler.sv
// Randomized bench for spmv_row_scheduler against a job-level model.
// Define SPMV_ROW_SCHED_PERF_EN to also check the perf counters.
module tb_spmv_row_scheduler;

  logic        clk, rstn;
  logic        cfg_start;
  logic [31:0] cfg_row_count, cfg_nnz_total;
  logic        busy, done;
  logic [2:0]  err;
  logic [31:0] rowptr_tdata;
  logic        rowptr_tvalid, rowptr_tready;
  logic        read_begin;
  logic [31:0] read_length;
  logic [31:0] times_tdata;
  logic        times_tvalid, times_tready;
  logic        out_beat_valid, out_beat_ready;
`ifdef SPMV_ROW_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
`endif

  int n_chk, n_fail;

  spmv_row_scheduler #(.ROWS_W(32)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .cfg_start      (cfg_start),
    .cfg_row_count  (cfg_row_count),
    .cfg_nnz_total  (cfg_nnz_total),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .rowptr_tdata   (rowptr_tdata),
    .rowptr_tvalid  (rowptr_tvalid),
    .rowptr_tready  (rowptr_tready),
    .read_begin     (read_begin),
    .read_length    (read_length),
    .times_tdata    (times_tdata),
    .times_tvalid   (times_tvalid),
    .times_tready   (times_tready),
    .out_beat_valid (out_beat_valid),
`ifdef SPMV_ROW_SCHED_PERF_EN
    .out_beat_ready (out_beat_ready),
    .perf_cycles    (perf_cycles),
    .perf_stall     (perf_stall)
`else
    .out_beat_ready (out_beat_ready)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    cfg_start      = 1'b0;
    rowptr_tvalid  = 1'b0;
    rowptr_tdata   = '0;
    times_tready   = 1'b0;
    out_beat_valid = 1'b0;
    out_beat_ready = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_err"},   32'(err), 0);
    check({tag, "_rb"},    32'(read_begin), 0);
    check({tag, "_rlen"},  read_length, 0);
    check({tag, "_tv"},    32'(times_tvalid), 0);
    check({tag, "_td"},    times_tdata, 0);
    check({tag, "_rdy"},   32'(rowptr_tready), 0);
  endtask

  // mode: 0 ready=1, 1 toggle, 2 random, 3 three forced stalls
  task automatic run_job(input int unsigned rc,
                         input int unsigned nnz,
                         input int unsigned ptr[$],
                         input int mode,
                         input bit early,
                         input bit abort);
    int unsigned exp_t[$];
    int unsigned got[$];
    logic [2:0]  exp_err;
    int unsigned prev, sum, nb;
    int idx, rb_cnt, done_cnt, after, beats, stalls, bcyc;
    bit rp_v, tog, poked, busy_seen, allow;

    exp_err = '0;
    prev = ptr[0];
    sum = 0;
    for (int i = 1; i <= int'(rc); i++) begin
      if (ptr[i] < prev) begin
        exp_t.push_back(0);
        exp_err[1] = 1'b1;
      end else begin
        exp_t.push_back(ptr[i] - prev);
        sum += ptr[i] - prev;
        prev = ptr[i];
      end
    end
    if (sum != nnz) exp_err[2] = 1'b1;
    nb = rc / 4;

    idx = 0; rb_cnt = 0; done_cnt = 0; after = 0;
    beats = 0; stalls = 0; bcyc = 0;
    rp_v = 0; tog = 0; poked = 0; busy_seen = 0;

    @(negedge clk);
    cfg_start     = 1'b1;
    cfg_row_count = rc;
    cfg_nnz_total = nnz;
    @(negedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cfg_start = 1'b0;
      if (busy_seen && !poked) begin
        cfg_start     = 1'b1;
        cfg_row_count = 6;
        cfg_nnz_total = $urandom;
        poked = 1;
      end
      if (!rp_v && idx < ptr.size() && $urandom_range(3) != 0)
        rp_v = 1;
      rowptr_tvalid = rp_v;
      rowptr_tdata  = (idx < ptr.size()) ? ptr[idx] : 32'd0;
      tog = ~tog;
      case (mode)
        0:       times_tready = 1'b1;
        1:       times_tready = tog;
        2:       times_tready = 1'($urandom_range(1));
        default: times_tready = (stalls >= 3);
      endcase
      allow = early ? (rb_cnt > 0) : (got.size() == rc);
      out_beat_valid = allow && beats < int'(nb) &&
                       $urandom_range(1) == 1;
      out_beat_ready = ($urandom_range(3) != 0);
      #1;
      busy_seen = busy;
      if (busy) bcyc++;
      if (times_tvalid && !times_tready) begin
        stalls++;
        check("rp_ready_in_stall", 32'(rowptr_tready), 0);
      end
      if (read_begin) begin
        rb_cnt++;
        check("read_length", read_length, nnz);
        check("times_before_rb", 32'(times_tvalid), 0);
      end
      if (done) done_cnt++;
      if (rowptr_tvalid && rowptr_tready) begin
        idx++;
        rp_v = 0;
      end
      if (times_tvalid && times_tready) got.push_back(times_tdata);
      if (out_beat_valid && out_beat_ready) beats++;
      if (abort && beats == 1) break;
      if (done_cnt > 0) after++;
      if (after == 3) break;
      @(negedge clk);
    end
    if (abort) return;

    check("done_seen", 32'(done_cnt), 1);
    check("read_begin_cnt", 32'(rb_cnt), 1);
    check("times_count", got.size(), exp_t.size());
    for (int i = 0; i < exp_t.size(); i++)
      check($sformatf("times[%0d]", i),
            (i < got.size()) ? got[i] : 32'hdead_beef, exp_t[i]);
    check("rowptr_consumed", 32'(idx), ptr.size());
    check("err", 32'(err), 32'(exp_err));
    check("busy_after", 32'(busy), 0);
    check("read_length_hold", read_length, nnz);
`ifdef SPMV_ROW_SCHED_PERF_EN
    check("perf_cycles", perf_cycles, bcyc);
    check("perf_stall", perf_stall, stalls);
    if (mode == 3) check("perf_stall_forced", perf_stall, 3);
`endif
  endtask

  task automatic bad_job(input int unsigned rc);
    int seen_busy, seen_rb, seen_done;
    seen_busy = 0; seen_rb = 0; seen_done = 0;
    @(negedge clk);
    cfg_start     = 1'b1;
    cfg_row_count = rc;
    cfg_nnz_total = 32'd5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cfg_start = 1'b0;
      #1;
      if (busy) seen_busy++;
      if (read_begin) seen_rb++;
      if (done) seen_done++;
    end
    check($sformatf("bad%0d_err", rc), 32'(err), 1);
    check($sformatf("bad%0d_busy", rc), 32'(seen_busy), 0);
    check($sformatf("bad%0d_rb", rc), 32'(seen_rb), 0);
    check($sformatf("bad%0d_done", rc), 32'(seen_done), 0);
  endtask

  initial begin
    int unsigned p[$];
    int unsigned rc, nnz, cur;
    n_chk = 0;
    n_fail = 0;
    rstn = 1'b0;
    cfg_row_count = '0;
    cfg_nnz_total = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    check_reset("reset");
    rstn = 1'b1;

    p = '{0, 3, 3, 7, 10};
    run_job(4, 10, p, 0, 0, 0);
    idle_inputs();
    run_job(4, 10, p, 1, 0, 0);
    idle_inputs();

    bad_job(6);
    bad_job(0);

    p = '{0, 5, 4, 8, 9};
    run_job(4, 9, p, 0, 0, 0);
    idle_inputs();
    run_job(4, 8, p, 2, 1, 0);
    idle_inputs();

    p = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    run_job(8, 8, p, 0, 0, 1);
    idle_inputs();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    #1;
    check_reset("midjob_reset");
    rstn = 1'b1;
    run_job(8, 8, p, 2, 0, 0);
    idle_inputs();

    p = '{2, 4, 7, 9, 12};
    run_job(4, 10, p, 3, 0, 0);
    idle_inputs();

    for (int j = 0; j < 8; j++) begin
      rc = 4 * $urandom_range(1, 6);
      p.delete();
      cur = $urandom_range(0, 1000);
      p.push_back(cur);
      for (int i = 0; i < int'(rc); i++) begin
        if ($urandom_range(9) == 0 && cur > 0) cur = cur - 1;
        else cur = cur + $urandom_range(0, 6);
        p.push_back(cur);
      end
      nnz = p[rc] - p[0];
      if ($urandom_range(3) == 0) nnz = nnz + 1;
      run_job(rc, nnz, p, $urandom_range(0, 2), 1'($urandom_range(1)), 0);
      idle_inputs();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
